// File: rtl/fifo_stream_serializer_if.sv
// fifo_stream_serializer_if
//   Bundles the FIFO read port, flush strobe and narrow output stream used by
//   fifo_stream_serializer.
//   master : serializer view (drives fifo_read_en and the out_* stream)
//   slave  : environment view (FIFO + consumer side)
//   Signals: fifo_empty, fifo_read_en, fifo_read_data[IN_WIDTH], flush,
//            out_valid, out_ready, out_data[OUT_WIDTH], out_last
interface fifo_stream_serializer_if #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8
);
    logic                 fifo_empty;
    logic                 fifo_read_en;
    logic [IN_WIDTH-1:0]  fifo_read_data;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_last;

    modport master (
        input  fifo_empty, fifo_read_data, flush, out_ready,
        output fifo_read_en, out_valid, out_data, out_last
    );

    modport slave (
        output fifo_empty, fifo_read_data, flush, out_ready,
        input  fifo_read_en, out_valid, out_data, out_last
    );
endinterface

// File: rtl/fifo_stream_serializer.sv
// fifo_stream_serializer
//   Drains one IN_WIDTH word at a time from a synchronous FIFO read port and
//   emits it as RATIO = IN_WIDTH/OUT_WIDTH narrow beats on a valid/ready
//   stream, flagging the final beat of each word with out_last. A new word is
//   popped on the same cycle the last beat transfers, so a steady FIFO gives
//   one beat per cycle with no bubble between words.
//   Ports:
//     clk  - system clock
//     rst  - asynchronous active-high reset
//     bus  - fifo_stream_serializer_if.master (FIFO read port, flush, stream)
//   Build option:
//     SERIALIZER_MSB_FIRST_EN - emit the most significant slice first
//     (default: least significant slice first). Timing and out_last unchanged.
module fifo_stream_serializer #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    fifo_stream_serializer_if.master  bus
);
    localparam int RATIO = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(RATIO - 1);

    typedef enum logic {S_EMPTY, S_BUSY} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [IN_WIDTH-1:0]   word_q, word_d;

    logic                  read_en;
    logic                  out_valid;
    logic                  out_last;
    logic [OUT_WIDTH-1:0]  out_data;
    logic [CNT_W-1:0]      sel;
    logic                  xfer;

    // Slice view of the held word; beat index selects a lane directly.
    logic [RATIO-1:0][OUT_WIDTH-1:0] beats;
    assign beats = word_q;

`ifdef SERIALIZER_MSB_FIRST_EN
    assign sel = LAST_BEAT - beat_cnt_q;
`else
    assign sel = beat_cnt_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            beat_cnt_q <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            word_q     <= word_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        word_d     = word_q;
        read_en    = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = '0;
        xfer       = 1'b0;

        unique case (state_q)
            S_EMPTY: begin
                if (!bus.flush && !bus.fifo_empty) begin
                    read_en    = 1'b1;
                    word_d     = bus.fifo_read_data;
                    beat_cnt_d = '0;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                out_valid = 1'b1;
                out_data  = beats[sel];
                out_last  = (beat_cnt_q == LAST_BEAT);
                xfer      = bus.out_ready;
                // Flush wins over everything: the presented beat may still
                // transfer, but the rest of the word is dropped and no pop occurs.
                if (bus.flush) begin
                    state_d    = S_EMPTY;
                    beat_cnt_d = '0;
                end else if (xfer) begin
                    if (out_last) begin
                        beat_cnt_d = '0;
                        if (!bus.fifo_empty) begin
                            read_en = 1'b1;
                            word_d  = bus.fifo_read_data;
                        end else begin
                            state_d = S_EMPTY;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    // Reset is asynchronous, so gate the pop strobe with it directly: a word
    // popped while reset is held would be lost.
    assign bus.fifo_read_en = read_en & ~rst;
    assign bus.out_valid    = out_valid;
    assign bus.out_data     = out_data;
    assign bus.out_last     = out_last;
endmodule
